kd_backtrack_node: RTL



---
 rtl/kd_pkg.sv | 43 ++++
 rtl/kd_backtrack_node_if.sv | 57 +++++
 rtl/kd_manhattan_comb.sv | 47 ++++
 rtl/kd_backtrack_node.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// kd_pkg: shared widths, helpers and FSM state encoding for the kd-tree backtrack engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kd_pkg;

  localparam int KD_DIM_DEF        = 3;
  localparam int KD_DATA_RANGE_DEF = 255;

  // Bits per coordinate.
  function automatic int dim_size(input int data_range);
    return $clog2(data_range);
  endfunction

  // Bits for a whole packed point; axis k lives at [k*dim_size +: dim_size].
  function automatic int center_size(input int dim, input int data_range);
    return dim * $clog2(data_range);
  endfunction

  // Bits for a Manhattan distance. The largest sum is dim*data_range.
  function automatic int dist_size(input int dim, input int data_range);
    return $clog2(data_range * dim);
  endfunction

  // Bits for an axis index. Kept at least 1 so a 1-D tree still has a port.
  function automatic int axis_size(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // Axis values outside 0..dim-1 fall back to axis 0.
  function automatic int axis_sel(input int axis, input int dim);
    return (axis >= 0 && axis < dim) ? axis : 0;
  endfunction

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_SEND1 = 3'd2;
  localparam logic [2:0] ST_WAIT1 = 3'd3;
  localparam logic [2:0] ST_PRUNE = 3'd4;
  localparam logic [2:0] ST_SEND2 = 3'd5;
  localparam logic [2:0] ST_WAIT2 = 3'd6;
  localparam logic [2:0] ST_REPLY = 3'd7;

endpackage

// File: rtl/kd_backtrack_node_if.sv
// kd_backtrack_node_if: bundles the parent query, child down/reply and parent reply channels.
// Latency: n/a (wires only).
// Backpressure: valid/ready on query, down, child and up channels.
// Ports: slave = engine side, master = parent/children side.
interface kd_backtrack_node_if #(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255
) ();
  import kd_pkg::*;

  localparam int CW = center_size(DIM, DATA_RANGE);
  localparam int DW = dist_size(DIM, DATA_RANGE);
  localparam int AW = axis_size(DIM);

  logic          query_valid;
  logic          query_ready;
  logic [CW-1:0] query_point;
  logic [CW-1:0] node_center;
  logic [AW-1:0] axis;
  logic          has_left;
  logic          has_right;
  logic          down_valid;
  logic          down_ready;
  logic          down_sel;
  logic [CW-1:0] down_point;
  logic          child_valid;
  logic          child_ready;
  logic [CW-1:0] child_best;
  logic [DW-1:0] child_dist;
  logic          up_valid;
  logic          up_ready;
  logic [CW-1:0] up_best;
  logic [DW-1:0] up_dist;

  modport slave (
    input  query_valid, query_point, node_center, axis, has_left, has_right,
    output query_ready,
    output down_valid, down_sel, down_point,
    input  down_ready,
    input  child_valid, child_best, child_dist,
    output child_ready,
    output up_valid, up_best, up_dist,
    input  up_ready
  );

  modport master (
    output query_valid, query_point, node_center, axis, has_left, has_right,
    input  query_ready,
    input  down_valid, down_sel, down_point,
    output down_ready,
    output child_valid, child_best, child_dist,
    input  child_ready,
    input  up_valid, up_best, up_dist,
    output up_ready
  );

endinterface

// File: rtl/kd_manhattan_comb.sv
// kd_manhattan_comb: Manhattan distance between two points plus the distance along one axis.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i/b_i packed points, axis_i split axis, dist_o full L1 distance, axis_dist_o |a_axis-b_axis|.
module kd_manhattan_comb
  import kd_pkg::*;
#(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255,
  localparam int CW = center_size(DIM, DATA_RANGE),
  localparam int DW = dist_size(DIM, DATA_RANGE),
  localparam int AW = axis_size(DIM),
  localparam int DS = dim_size(DATA_RANGE)
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic [AW-1:0] axis_i,
  output logic [DW-1:0] dist_o,
  output logic [DW-1:0] axis_dist_o
);

  logic [DS-1:0] ak, bk, dk;
  logic [DW-1:0] sum;
  int            ax;

  always_comb begin
    sum = '0;
    ak  = '0;
    bk  = '0;
    dk  = '0;
    for (int k = 0; k < DIM; k++) begin
      ak  = a_i[k*DS +: DS];
      bk  = b_i[k*DS +: DS];
      dk  = (ak > bk) ? (ak - bk) : (bk - ak);
      sum = sum + DW'(dk);
    end
    dist_o = sum;
  end

  always_comb begin
    ax          = axis_sel(int'(axis_i), DIM);
    axis_dist_o = (a_i[ax*DS +: DS] > b_i[ax*DS +: DS]) ?
                  DW'(a_i[ax*DS +: DS] - b_i[ax*DS +: DS]) :
                  DW'(b_i[ax*DS +: DS] - a_i[ax*DS +: DS]);
  end

endmodule

// File: rtl/kd_backtrack_node.sv
// kd_backtrack_node: per-node kd-tree nearest-neighbour engine (descend near, maybe far, reply best).
// Latency: leaf replies in the 3rd cycle after query accept (CALC, PRUNE, REPLY); each child visit adds its round trip.
// Backpressure: valid/ready on every channel; valids and payloads hold until their transfer.
// Ports: clk, rst (async active-low), bus (kd_backtrack_node_if.slave).
// Optional: define KD_BT_STATS_EN to add saturating visit_count/prune_count outputs.
module kd_backtrack_node
  import kd_pkg::*;
#(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  kd_backtrack_node_if.slave     bus
`ifdef KD_BT_STATS_EN
  ,
  output logic [15:0]            visit_count,
  output logic [15:0]            prune_count
`endif
);

  localparam int CW = center_size(DIM, DATA_RANGE);
  localparam int DW = dist_size(DIM, DATA_RANGE);
  localparam int DS = dim_size(DATA_RANGE);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] qpt_q, qpt_d;
  logic [CW-1:0] best_q, best_d;
  logic [DW-1:0] best_dist_q, best_dist_d;
  logic          near_q, near_d;     // 1 = right child is the near side

  logic [DW-1:0] dist_w, axis_dist_w;
  logic [DS-1:0] q_ax, c_ax;
  int            ax;
  logic          near_right_w;
  logic          near_present_w;
  logic          far_present_w;
  logic          visit_far_w;

  kd_manhattan_comb #(.DIM(DIM), .DATA_RANGE(DATA_RANGE)) u_dist (
    .a_i         (qpt_q),
    .b_i         (bus.node_center),
    .axis_i      (bus.axis),
    .dist_o      (dist_w),
    .axis_dist_o (axis_dist_w)
  );

  always_comb begin
    ax             = axis_sel(int'(bus.axis), DIM);
    q_ax           = qpt_q[ax*DS +: DS];
    c_ax           = bus.node_center[ax*DS +: DS];
    // Ties on the split axis go right.
    near_right_w   = !(q_ax < c_ax);
    near_present_w = near_right_w ? bus.has_right : bus.has_left;
    // In PRUNE the near side is already registered.
    far_present_w  = near_q ? bus.has_left : bus.has_right;
    visit_far_w    = far_present_w && (best_dist_q > axis_dist_w);
  end

  always_comb begin
    state_d     = state_q;
    qpt_d       = qpt_q;
    best_d      = best_q;
    best_dist_d = best_dist_q;
    near_d      = near_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.query_valid) begin
          qpt_d   = bus.query_point;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        best_d      = bus.node_center;
        best_dist_d = dist_w;
        near_d      = near_right_w;
        state_d     = near_present_w ? ST_SEND1 : ST_PRUNE;
      end
      ST_SEND1: if (bus.down_ready) state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (bus.child_valid) begin
          if (bus.child_dist < best_dist_q) begin
            best_d      = bus.child_best;
            best_dist_d = bus.child_dist;
          end
          state_d = ST_PRUNE;
        end
      end
      ST_PRUNE: state_d = visit_far_w ? ST_SEND2 : ST_REPLY;
      ST_SEND2: if (bus.down_ready) state_d = ST_WAIT2;
      ST_WAIT2: begin
        if (bus.child_valid) begin
          if (bus.child_dist < best_dist_q) begin
            best_d      = bus.child_best;
            best_dist_d = bus.child_dist;
          end
          state_d = ST_REPLY;
        end
      end
      ST_REPLY: if (bus.up_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      qpt_q       <= '0;
      best_q      <= '0;
      best_dist_q <= '0;
      near_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qpt_q       <= qpt_d;
      best_q      <= best_d;
      best_dist_q <= best_dist_d;
      near_q      <= near_d;
    end
  end

  assign bus.query_ready = (state_q == ST_IDLE);
  assign bus.down_valid  = (state_q == ST_SEND1) || (state_q == ST_SEND2);
  assign bus.down_sel    = (state_q == ST_SEND2) ? ~near_q : near_q;
  assign bus.down_point  = qpt_q;
  assign bus.child_ready = (state_q == ST_WAIT1) || (state_q == ST_WAIT2);
  assign bus.up_valid    = (state_q == ST_REPLY);
  assign bus.up_best     = best_q;
  assign bus.up_dist     = best_dist_q;

`ifdef KD_BT_STATS_EN
  logic [15:0] visit_q, prune_q;
  logic        down_xfer_w, prune_skip_w;

  assign down_xfer_w  = bus.down_valid && bus.down_ready;
  assign prune_skip_w = (state_q == ST_PRUNE) && far_present_w && !visit_far_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      visit_q <= '0;
      prune_q <= '0;
    end else begin
      if (down_xfer_w && (visit_q != 16'hFFFF)) visit_q <= visit_q + 16'd1;
      if (prune_skip_w && (prune_q != 16'hFFFF)) prune_q <= prune_q + 16'd1;
    end
  end

  assign visit_count = visit_q;
  assign prune_count = prune_q;
`endif

endmodule
